// File: rtl/ssd1306_spi_rx.sv
// SSD1306-compatible SPI slave: synchronises the AVR SPI pins, frames bytes,
// decodes the addressing/display command subset and drives a framebuffer
// write port laid out as {page, col}.
module ssd1306_spi_rx #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned COLS        = 128,
  parameter int unsigned PAGES       = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       spi_scl,
  input  logic       spi_mosi,
  input  logic       spi_dc,
  output logic       fb_we,
  output logic [9:0] fb_addr,
  output logic [7:0] fb_wdata,
  output logic       frame_done,
  output logic       disp_on,
  output logic       invert,
  output logic [7:0] contrast
);

  typedef enum logic [1:0] {
    ST_CMD,
    ST_ARG1,
    ST_ARG2
  } state_e;

  // Input synchronisers and edge detect
  logic [SYNC_STAGES-1:0] scl_sync_q, mosi_sync_q, dc_sync_q;
  logic                   scl_prev_q;
  logic                   scl_s, mosi_s, dc_s, scl_rise;

  // Byte assembly
  logic [7:0] shift_q, shift_d;
  logic [2:0] bitcnt_q, bitcnt_d;
  logic       byte_valid_q, byte_valid_d;
  logic [7:0] byte_q, byte_d;
  logic       byte_dc_q, byte_dc_d;

  // Command FSM and decoded state
  state_e     state_q, state_d;
  logic [7:0] cmd_q, cmd_d;
  logic [1:0] mode_q, mode_d;
  logic [6:0] col_q, col_d, col_start_q, col_start_d, col_end_q, col_end_d;
  logic [2:0] page_q, page_d, page_start_q, page_start_d, page_end_q, page_end_d;
  logic       disp_on_q, disp_on_d, invert_q, invert_d;
  logic [7:0] contrast_q, contrast_d;

  // Write port
  logic       fb_we_q, fb_we_d, frame_done_q, frame_done_d;
  logic [9:0] fb_addr_q, fb_addr_d;
  logic [7:0] fb_wdata_q, fb_wdata_d;

  logic       col_last, page_last;
  logic [6:0] col_inc;
  logic [2:0] page_inc;

  assign scl_s    = scl_sync_q[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
  assign dc_s     = dc_sync_q[SYNC_STAGES-1];
  assign scl_rise = scl_s & ~scl_prev_q;

  assign col_last  = (col_q == col_end_q);
  assign page_last = (page_q == page_end_q);
  assign col_inc   = col_q + 7'd1;
  assign page_inc  = page_q + 3'd1;

  // Commands that consume exactly one or two following argument bytes
  function automatic logic takes_arg(input logic [7:0] b);
    case (b)
      8'h20, 8'h21, 8'h22, 8'h81,
      8'hA8, 8'hD3, 8'hD5, 8'hD9, 8'hDA, 8'hDB, 8'h8D: takes_arg = 1'b1;
      default:                                          takes_arg = 1'b0;
    endcase
  endfunction

  // Pin synchronisers plus delayed scl for rising-edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync_q  <= '0;
      mosi_sync_q <= '0;
      dc_sync_q   <= '0;
      scl_prev_q  <= 1'b0;
    end else begin
      scl_sync_q  <= {scl_sync_q[SYNC_STAGES-2:0], spi_scl};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
      dc_sync_q   <= {dc_sync_q[SYNC_STAGES-2:0], spi_dc};
      scl_prev_q  <= scl_s;
    end
  end

  // Shift bits in MSB first; the 8th edge publishes the byte and its dc
  always_comb begin
    shift_d      = shift_q;
    bitcnt_d     = bitcnt_q;
    byte_valid_d = 1'b0;
    byte_d       = byte_q;
    byte_dc_d    = byte_dc_q;
    if (scl_rise) begin
      shift_d  = {shift_q[6:0], mosi_s};
      bitcnt_d = bitcnt_q + 3'd1;
      if (bitcnt_q == 3'd7) begin
        byte_valid_d = 1'b1;
        byte_d       = {shift_q[6:0], mosi_s};
        byte_dc_d    = dc_s;
      end
    end
  end

  // Byte assembly registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q      <= '0;
      bitcnt_q     <= '0;
      byte_valid_q <= 1'b0;
      byte_q       <= '0;
      byte_dc_q    <= 1'b0;
    end else begin
      shift_q      <= shift_d;
      bitcnt_q     <= bitcnt_d;
      byte_valid_q <= byte_valid_d;
      byte_q       <= byte_d;
      byte_dc_q    <= byte_dc_d;
    end
  end

  // Command FSM next state; a data byte always returns to CMD
  always_comb begin
    state_d = state_q;
    if (byte_valid_q) begin
      if (byte_dc_q) begin
        state_d = ST_CMD;
      end else begin
        case (state_q)
          ST_CMD:  state_d = takes_arg(byte_q) ? ST_ARG1 : ST_CMD;
          ST_ARG1: state_d = (cmd_q == 8'h21 || cmd_q == 8'h22) ? ST_ARG2 : ST_CMD;
          default: state_d = ST_CMD;
        endcase
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_CMD;
    else        state_q <= state_d;
  end

  // Command decode, data write generation and address advance
  always_comb begin
    cmd_d        = cmd_q;
    mode_d       = mode_q;
    col_d        = col_q;
    col_start_d  = col_start_q;
    col_end_d    = col_end_q;
    page_d       = page_q;
    page_start_d = page_start_q;
    page_end_d   = page_end_q;
    disp_on_d    = disp_on_q;
    invert_d     = invert_q;
    contrast_d   = contrast_q;
    fb_we_d      = 1'b0;
    frame_done_d = 1'b0;
    fb_addr_d    = fb_addr_q;
    fb_wdata_d   = fb_wdata_q;
    if (byte_valid_q) begin
      if (byte_dc_q) begin
        fb_we_d      = 1'b1;
        fb_addr_d    = {page_q, col_q};
        fb_wdata_d   = byte_q;
        frame_done_d = ~mode_q[1] & col_last & page_last;
        case (mode_q)
          2'd0: begin
            if (col_last) begin
              col_d  = col_start_q;
              page_d = page_last ? page_start_q : page_inc;
            end else begin
              col_d = col_inc;
            end
          end
          2'd1: begin
            if (page_last) begin
              page_d = page_start_q;
              col_d  = col_last ? col_start_q : col_inc;
            end else begin
              page_d = page_inc;
            end
          end
          default: col_d = col_last ? col_start_q : col_inc;
        endcase
      end else begin
        case (state_q)
          ST_CMD: begin
            cmd_d = byte_q;
            if (byte_q[7:4] == 4'h0)          col_d[3:0] = byte_q[3:0];
            else if (byte_q[7:3] == 5'b00010) col_d[6:4] = byte_q[2:0];
            else if (byte_q[7:3] == 5'b10110) page_d     = byte_q[2:0];
            case (byte_q)
              8'hAE:   disp_on_d = 1'b0;
              8'hAF:   disp_on_d = 1'b1;
              8'hA6:   invert_d  = 1'b0;
              8'hA7:   invert_d  = 1'b1;
              default: ;
            endcase
          end
          ST_ARG1: begin
            case (cmd_q)
              8'h20:   mode_d       = byte_q[1:0];
              8'h21:   col_start_d  = byte_q[6:0];
              8'h22:   page_start_d = byte_q[2:0];
              8'h81:   contrast_d   = byte_q;
              default: ;
            endcase
          end
          default: begin
            if (cmd_q == 8'h21) begin
              col_end_d = byte_q[6:0];
              col_d     = col_start_q;
            end else if (cmd_q == 8'h22) begin
              page_end_d = byte_q[2:0];
              page_d     = page_start_q;
            end
          end
        endcase
      end
    end
  end

  // Decoded state and write port registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_q        <= '0;
      mode_q       <= 2'd2;
      col_q        <= '0;
      col_start_q  <= '0;
      col_end_q    <= 7'(COLS - 1);
      page_q       <= '0;
      page_start_q <= '0;
      page_end_q   <= 3'(PAGES - 1);
      disp_on_q    <= 1'b0;
      invert_q     <= 1'b0;
      contrast_q   <= 8'h7F;
      fb_we_q      <= 1'b0;
      frame_done_q <= 1'b0;
      fb_addr_q    <= '0;
      fb_wdata_q   <= '0;
    end else begin
      cmd_q        <= cmd_d;
      mode_q       <= mode_d;
      col_q        <= col_d;
      col_start_q  <= col_start_d;
      col_end_q    <= col_end_d;
      page_q       <= page_d;
      page_start_q <= page_start_d;
      page_end_q   <= page_end_d;
      disp_on_q    <= disp_on_d;
      invert_q     <= invert_d;
      contrast_q   <= contrast_d;
      fb_we_q      <= fb_we_d;
      frame_done_q <= frame_done_d;
      fb_addr_q    <= fb_addr_d;
      fb_wdata_q   <= fb_wdata_d;
    end
  end

  assign fb_we      = fb_we_q;
  assign fb_addr    = fb_addr_q;
  assign fb_wdata   = fb_wdata_q;
  assign frame_done = frame_done_q;
  assign disp_on    = disp_on_q;
  assign invert     = invert_q;
  assign contrast   = contrast_q;

endmodule

// File: tb/tb_ssd1306_spi_rx.sv
// Bench for ssd1306_spi_rx: SPI byte driver, behavioural controller model
// producing expected framebuffer writes, and a per-cycle write checker.
`timescale 1ns/1ps
module tb_ssd1306_spi_rx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       spi_scl = 1'b0, spi_mosi = 1'b0, spi_dc = 1'b0;
  logic       fb_we, frame_done, disp_on, invert;
  logic [9:0] fb_addr;
  logic [7:0] fb_wdata, contrast;

  always #5 clk = ~clk;

  ssd1306_spi_rx #(.SYNC_STAGES(2), .COLS(128), .PAGES(8)) dut (
    .clk(clk), .rst_n(rst_n), .spi_scl(spi_scl), .spi_mosi(spi_mosi), .spi_dc(spi_dc),
    .fb_we(fb_we), .fb_addr(fb_addr), .fb_wdata(fb_wdata), .frame_done(frame_done),
    .disp_on(disp_on), .invert(invert), .contrast(contrast)
  );

  typedef struct packed {
    logic [9:0] addr;
    logic [7:0] data;
    logic       done;
  } wr_t;

  wr_t exp_q[$];
  wr_t log_q[$];
  int  nerr = 0, nchk = 0;

  // Model state: plain integers following the controller's documented rules
  int m_mode, m_col, m_page, m_cs, m_ce, m_ps, m_pe, m_argn, m_cmd;
  int m_disp, m_inv, m_con;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    nchk++;
    if (act !== req) begin
      nerr++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic model_reset();
    m_mode = 2; m_col = 0; m_page = 0; m_cs = 0; m_ce = 127; m_ps = 0; m_pe = 7;
    m_argn = 0; m_cmd = 0; m_disp = 0; m_inv = 0; m_con = 'h7F;
    exp_q.delete();
  endtask

  task automatic model_byte(input int b, input logic dc);
    wr_t w;
    if (dc) begin
      m_argn = 0;
      w.addr = 10'(m_page * 128 + m_col);
      w.data = 8'(b);
      w.done = (m_mode < 2) && (m_page == m_pe) && (m_col == m_ce);
      exp_q.push_back(w);
      if (m_mode == 0) begin
        if (m_col == m_ce) begin
          m_col = m_cs;
          m_page = (m_page == m_pe) ? m_ps : (m_page + 1) % 8;
        end else m_col = (m_col + 1) % 128;
      end else if (m_mode == 1) begin
        if (m_page == m_pe) begin
          m_page = m_ps;
          m_col = (m_col == m_ce) ? m_cs : (m_col + 1) % 128;
        end else m_page = (m_page + 1) % 8;
      end else begin
        m_col = (m_col == m_ce) ? m_cs : (m_col + 1) % 128;
      end
    end else if (m_argn == 0) begin
      if (b < 'h10) m_col = (m_col / 16) * 16 + b;
      else if (b < 'h18) m_col = (b - 'h10) * 16 + (m_col % 16);
      else if (b >= 'hB0 && b <= 'hB7) m_page = b - 'hB0;
      else if (b == 'hAE) m_disp = 0;
      else if (b == 'hAF) m_disp = 1;
      else if (b == 'hA6) m_inv = 0;
      else if (b == 'hA7) m_inv = 1;
      else if (b inside {'h20, 'h21, 'h22, 'h81, 'hA8, 'hD3, 'hD5, 'hD9, 'hDA, 'hDB, 'h8D}) begin
        m_cmd = b; m_argn = 1;
      end
    end else if (m_argn == 1) begin
      m_argn = 0;
      if (m_cmd == 'h20) m_mode = b % 4 == 3 ? 2 : b % 4;
      else if (m_cmd == 'h81) m_con = b;
      else if (m_cmd == 'h21) begin m_cs = b % 128; m_argn = 2; end
      else if (m_cmd == 'h22) begin m_ps = b % 8; m_argn = 2; end
    end else begin
      m_argn = 0;
      if (m_cmd == 'h21) begin m_ce = b % 128; m_col = m_cs; end
      else begin m_pe = b % 8; m_page = m_ps; end
    end
  endtask

  // Every write the DUT makes must be the next one the model predicted
  always @(negedge clk) begin
    wr_t e, a;
    if (rst_n) begin
      if (frame_done && !fb_we) check("frame_done_without_we", 1, 0);
      if (fb_we) begin
        a.addr = fb_addr; a.data = fb_wdata; a.done = frame_done;
        log_q.push_back(a);
        if (exp_q.size() == 0) check("unexpected_write", 1, 0);
        else begin
          e = exp_q.pop_front();
          check("wr_addr", 32'(fb_addr), 32'(e.addr));
          check("wr_data", 32'(fb_wdata), 32'(e.data));
          check("wr_done", 32'(frame_done), 32'(e.done));
        end
      end
    end
  end

  task automatic send_bit(input logic b, input logic dc);
    spi_mosi = b; spi_dc = dc;
    repeat (3) @(negedge clk);
    spi_scl = 1'b1;
    repeat (3) @(negedge clk);
    spi_scl = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic dc);
    model_byte(int'(b), dc);
    for (int i = 7; i >= 0; i--) send_bit(b[i], dc);
  endtask

  // dc toggled for the first seven bits; only the value at the last bit counts
  task automatic send_byte_mix(input logic [7:0] b, input logic dc_last);
    model_byte(int'(b), dc_last);
    for (int i = 7; i >= 1; i--) send_bit(b[i], ~dc_last);
    send_bit(b[0], dc_last);
  endtask

  task automatic flush();
    repeat (12) @(negedge clk);
    check("pending_writes", 32'(exp_q.size()), 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; spi_scl = 1'b0; spi_mosi = 1'b0; spi_dc = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    log_q.delete();
  endtask

  task automatic check_status();
    check("disp_on", 32'(disp_on), 32'(m_disp));
    check("invert", 32'(invert), 32'(m_inv));
    check("contrast", 32'(contrast), 32'(m_con));
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int ndone;
    do_reset();
    check("rst_fb_we", 32'(fb_we), 0);
    check("rst_fb_addr", 32'(fb_addr), 0);
    check("rst_fb_wdata", 32'(fb_wdata), 0);
    check("rst_frame_done", 32'(frame_done), 0);
    check("rst_disp_on", 32'(disp_on), 0);
    check("rst_invert", 32'(invert), 0);
    check("rst_contrast", 32'(contrast), 32'h7F);

    // 1: page mode data
    send_byte(8'h55, 1'b1);
    send_byte(8'hC3, 1'b1);
    flush();
    check("t1_nwr", 32'(log_q.size()), 2);
    if (log_q.size() >= 2) begin
      check("t1_addr0", 32'(log_q[0].addr), 0);
      check("t1_data0", 32'(log_q[0].data), 32'h55);
      check("t1_addr1", 32'(log_q[1].addr), 1);
    end

    // 2: horizontal full frame
    do_reset();
    send_byte(8'h20, 0); send_byte(8'h00, 0);
    send_byte(8'h21, 0); send_byte(8'h00, 0); send_byte(8'h7F, 0);
    send_byte(8'h22, 0); send_byte(8'h00, 0); send_byte(8'h07, 0);
    for (int i = 0; i < 1025; i++) send_byte(8'(i * 7 + 3), 1'b1);
    flush();
    check("t2_nwr", 32'(log_q.size()), 1025);
    if (log_q.size() == 1025) begin
      ndone = 0;
      for (int i = 0; i < 1025; i++) if (log_q[i].done) ndone++;
      check("t2_ndone", 32'(ndone), 1);
      check("t2_addr1023", 32'(log_q[1023].addr), 1023);
      check("t2_done1023", 32'(log_q[1023].done), 1);
      check("t2_addr1024", 32'(log_q[1024].addr), 0);
    end

    // 3: vertical window
    do_reset();
    send_byte(8'h20, 0); send_byte(8'h01, 0);
    send_byte(8'h21, 0); send_byte(8'h05, 0); send_byte(8'h06, 0);
    send_byte(8'h22, 0); send_byte(8'h02, 0); send_byte(8'h03, 0);
    for (int i = 0; i < 5; i++) send_byte(8'(8'h10 + i), 1'b1);
    flush();
    check("t3_nwr", 32'(log_q.size()), 5);
    if (log_q.size() == 5) begin
      check("t3_a0", 32'(log_q[0].addr), 261);
      check("t3_a1", 32'(log_q[1].addr), 389);
      check("t3_a2", 32'(log_q[2].addr), 262);
      check("t3_a3", 32'(log_q[3].addr), 390);
      check("t3_a4", 32'(log_q[4].addr), 261);
      check("t3_done3", 32'(log_q[3].done), 1);
      check("t3_done2", 32'(log_q[2].done), 0);
    end

    // 4: page/column set commands
    do_reset();
    send_byte(8'hB3, 0); send_byte(8'h04, 0); send_byte(8'h12, 0);
    send_byte(8'hAA, 1'b1);
    flush();
    check("t4_nwr", 32'(log_q.size()), 1);
    if (log_q.size() == 1) begin
      check("t4_addr", 32'(log_q[0].addr), 32'h1A4);
      check("t4_data", 32'(log_q[0].data), 32'hAA);
    end

    // 5: display status commands
    do_reset();
    send_byte(8'hAF, 0); send_byte(8'hA7, 0);
    send_byte(8'h81, 0); send_byte(8'h40, 0); send_byte(8'hAE, 0);
    flush();
    check("t5_nwr", 32'(log_q.size()), 0);
    check("t5_disp_on", 32'(disp_on), 0);
    check("t5_invert", 32'(invert), 1);
    check("t5_contrast", 32'(contrast), 32'h40);
    check_status();

    // 6: reset mid-byte discards partial bits
    do_reset();
    for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b1);
    do_reset();
    send_byte(8'hF0, 1'b1);
    flush();
    check("t6_nwr", 32'(log_q.size()), 1);
    if (log_q.size() == 1) begin
      check("t6_addr", 32'(log_q[0].addr), 0);
      check("t6_data", 32'(log_q[0].data), 32'hF0);
    end

    // 7: dc taken at the 8th bit, data aborts a pending argument, discarded arg
    do_reset();
    send_byte_mix(8'h3C, 1'b1);
    send_byte_mix(8'hAF, 1'b0);
    send_byte(8'h81, 0);
    send_byte(8'h99, 1'b1);
    send_byte(8'hA8, 0); send_byte(8'hA7, 0);
    send_byte(8'h20, 0); send_byte(8'h03, 0);
    send_byte(8'h7E, 1'b1);
    flush();
    check("t7_nwr", 32'(log_q.size()), 3);
    check("t7_disp_on", 32'(disp_on), 1);
    check("t7_contrast", 32'(contrast), 32'h7F);
    check("t7_invert", 32'(invert), 0);
    if (log_q.size() == 3) begin
      check("t7_data0", 32'(log_q[0].data), 32'h3C);
      check("t7_addr1", 32'(log_q[1].addr), 1);
      check("t7_data1", 32'(log_q[1].data), 32'h99);
      check("t7_addr2", 32'(log_q[2].addr), 2);
    end
    check_status();

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
